mmio_shift_unit: RTL and testbench

//  Memory-mapped iterative shift coprocessor; responder on the riscv_single_top data-memory port.

---
 rtl/mmio_shift_unit.sv | 126 ++++++++++++
 tb/tb_mmio_shift_unit.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_shift_unit.sv
// Memory-mapped iterative shift coprocessor: firmware loads OPERAND/SHAMT, starts via CTRL,
// polls STATUS and reads RESULT. Shifts SHIFT_PER_CYCLE bits per clock (1, 2 or 4).
module mmio_shift_unit #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
    parameter int          SHIFT_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic        done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] STEP_MAX = 5'(SHIFT_PER_CYCLE);

    localparam logic [2:0] SEL_OPERAND = 3'd0;
    localparam logic [2:0] SEL_SHAMT   = 3'd1;
    localparam logic [2:0] SEL_CTRL    = 3'd2;
    localparam logic [2:0] SEL_STATUS  = 3'd3;
    localparam logic [2:0] SEL_RESULT  = 3'd4;

    state_t      state;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [31:0] result;
    logic [31:0] work;
    logic [4:0]  rem;
    logic        busy;
    logic        done;

    logic [31:0] offset;
    logic [2:0]  sel;
    logic        wr_en;
    logic        start_ok;
    logic [4:0]  step;

    function automatic logic [31:0] shift_step(input logic [31:0] v,
                                               input logic [1:0]  kind,
                                               input logic [4:0]  s);
        logic signed [31:0] sv;
        sv = v;
        case (kind)
            2'b00:   return v << s;
            2'b01:   return v >> s;
            default: return sv >>> s;
        endcase
    endfunction

    // Unsigned subtract also rejects addresses below BASE_ADDR (they wrap to huge offsets).
    assign offset   = addr - BASE_ADDR;
    assign hit      = (offset < 32'h0000_0014);
    assign sel      = offset[4:2];
    assign wr_en    = we && hit && (state != SHIFT);
    assign start_ok = wr_en && (sel == SEL_CTRL) && wd[0] && (wd[2:1] != 2'b11);
    assign step     = (rem < STEP_MAX) ? rem : STEP_MAX;
    assign done_o   = done;

    always_comb begin
        rd = 32'h0;
        if (hit) begin
            case (sel)
                SEL_OPERAND: rd = operand;
                SEL_SHAMT:   rd = {27'h0, shamt};
                SEL_CTRL:    rd = {29'h0, op, 1'b0};
                SEL_STATUS:  rd = {30'h0, done, busy};
                SEL_RESULT:  rd = result;
                default:     rd = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            operand <= 32'h0;
            shamt   <= 5'h0;
            op      <= 2'b00;
            result  <= 32'h0;
            work    <= 32'h0;
            rem     <= 5'h0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (wr_en && sel == SEL_OPERAND)
                operand <= wd;
            if (wr_en && sel == SEL_SHAMT)
                shamt <= wd[4:0];

            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        work  <= operand;
                        rem   <= shamt;
                        op    <= wd[2:1];
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rem == 5'h0) begin
                        result <= work;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        work <= shift_step(work, op, step);
                        rem  <= rem - step;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_shift_unit.sv
// Directed testbench for mmio_shift_unit; a second instance with SHIFT_PER_CYCLE=4 shares the bus.
`timescale 1ns/1ps
module tb_mmio_shift_unit;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] R_OPERAND = 32'h00;
    localparam logic [31:0] R_SHAMT   = 32'h04;
    localparam logic [31:0] R_CTRL    = 32'h08;
    localparam logic [31:0] R_STATUS  = 32'h0C;
    localparam logic [31:0] R_RESULT  = 32'h10;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd, rd4;
    logic        hit, hit4;
    logic        done_o, done_o4;

    int checks = 0;
    int errors = 0;

    mmio_shift_unit #(.BASE_ADDR(BASE), .SHIFT_PER_CYCLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .wd(wd),
        .rd(rd), .hit(hit), .done_o(done_o)
    );

    mmio_shift_unit #(.BASE_ADDR(BASE), .SHIFT_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .wd(wd),
        .rd(rd4), .hit(hit4), .done_o(done_o4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic rd_reg(input logic [31:0] off, output logic [31:0] v, output logic [31:0] v4);
        addr = BASE + off;
        #1;
        v  = rd;
        v4 = rd4;
    endtask

    task automatic wait_done();
        logic [31:0] s, s4;
        int n;
        n = 0;
        rd_reg(R_STATUS, s, s4);
        while (s[1] !== 1'b1 && n < 200) begin
            @(negedge clk);
            rd_reg(R_STATUS, s, s4);
            n++;
        end
        checks++;
        if (s[1] !== 1'b1) begin
            errors++;
            $display("FAIL wait_done timeout: status=%h required done", s);
        end
    endtask

    task automatic count_busy(output int n, output int n4);
        logic [31:0] s, s4;
        n = 0;
        n4 = 0;
        for (int i = 0; i < 100; i++) begin
            rd_reg(R_STATUS, s, s4);
            if (s[0]) n++;
            if (s4[0]) n4++;
            if (!s[0] && !s4[0]) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] v, v4;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rd_reg(32'(i * 4), v, v4);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg[%0d]: got %h required %h", i, v, 32'h0);
            end
        end
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_done_o: got %b required 0", done_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sra();
        logic [31:0] v, v4;
        int n, n4;
        wr(BASE + R_OPERAND, 32'h8);
        wr(BASE + R_SHAMT, 32'h2);
        wr(BASE + R_CTRL, 32'h5);
        count_busy(n, n4);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL sra_busy_cycles: got %0d required 3", n);
        end
        rd_reg(R_STATUS, v, v4);
        checks++;
        if (v !== 32'h2) begin
            errors++;
            $display("FAIL sra_status: got %h required %h", v, 32'h2);
        end
        rd_reg(R_RESULT, v, v4);
        checks++;
        if (v !== 32'h2) begin
            errors++;
            $display("FAIL sra_result: got %h required %h", v, 32'h2);
        end
        rd_reg(R_CTRL, v, v4);
        checks++;
        if (v !== 32'h4) begin
            errors++;
            $display("FAIL sra_ctrl_readback: got %h required %h", v, 32'h4);
        end
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL sra_done_o: got %b required 1", done_o);
        end
    endtask

    task automatic test_sra_neg();
        logic [31:0] v, v4;
        wr(BASE + R_OPERAND, 32'hFFFF_FFF8);
        wr(BASE + R_SHAMT, 32'h2);
        wr(BASE + R_CTRL, 32'h5);
        wait_done();
        rd_reg(R_RESULT, v, v4);
        checks++;
        if (v !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL sra_neg_result: got %h required %h", v, 32'hFFFF_FFFE);
        end
        wr(BASE + R_CTRL, 32'h3);
        wait_done();
        rd_reg(R_RESULT, v, v4);
        checks++;
        if (v !== 32'h3FFF_FFFE) begin
            errors++;
            $display("FAIL srl_neg_result: got %h required %h", v, 32'h3FFF_FFFE);
        end
    endtask

    task automatic test_sll_max();
        logic [31:0] v, v4;
        int n, n4;
        wr(BASE + R_OPERAND, 32'h1);
        wr(BASE + R_SHAMT, 32'hFFFF_FFFF);
        rd_reg(R_SHAMT, v, v4);
        checks++;
        if (v !== 32'h1F) begin
            errors++;
            $display("FAIL shamt_mask: got %h required %h", v, 32'h1F);
        end
        wr(BASE + R_CTRL, 32'h1);
        count_busy(n, n4);
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL sll_busy_cycles: got %0d required 32", n);
        end
        checks++;
        if (n4 != 9) begin
            errors++;
            $display("FAIL sll_busy_cycles_x4: got %0d required 9", n4);
        end
        rd_reg(R_RESULT, v, v4);
        checks++;
        if (v !== 32'h8000_0000) begin
            errors++;
            $display("FAIL sll_result: got %h required %h", v, 32'h8000_0000);
        end
        checks++;
        if (v4 !== 32'h8000_0000) begin
            errors++;
            $display("FAIL sll_result_x4: got %h required %h", v4, 32'h8000_0000);
        end
    endtask

    task automatic test_zero_and_busy();
        logic [31:0] v, v4;
        int n, n4;
        wr(BASE + R_OPERAND, 32'h1234_5678);
        wr(BASE + R_SHAMT, 32'h0);
        wr(BASE + R_CTRL, 32'h1);
        count_busy(n, n4);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL zero_busy_cycles: got %0d required 1", n);
        end
        rd_reg(R_RESULT, v, v4);
        checks++;
        if (v !== 32'h1234_5678) begin
            errors++;
            $display("FAIL zero_result: got %h required %h", v, 32'h1234_5678);
        end
        // 0x12345678 << 20 = 0x67800000; mid-shift writes must not disturb it
        wr(BASE + R_SHAMT, 32'd20);
        wr(BASE + R_CTRL, 32'h1);
        wr(BASE + R_OPERAND, 32'hDEAD);
        wr(BASE + R_CTRL, 32'h1);
        rd_reg(R_RESULT, v, v4);
        checks++;
        if (v !== 32'h1234_5678) begin
            errors++;
            $display("FAIL busy_result_hold: got %h required %h", v, 32'h1234_5678);
        end
        wait_done();
        rd_reg(R_RESULT, v, v4);
        checks++;
        if (v !== 32'h6780_0000) begin
            errors++;
            $display("FAIL busy_result: got %h required %h", v, 32'h6780_0000);
        end
        rd_reg(R_OPERAND, v, v4);
        checks++;
        if (v !== 32'h1234_5678) begin
            errors++;
            $display("FAIL busy_operand_ignored: got %h required %h", v, 32'h1234_5678);
        end
    endtask

    task automatic test_reserved_unmapped();
        logic [31:0] v, v4;
        wr(BASE + R_CTRL, 32'h7);
        @(negedge clk);
        rd_reg(R_STATUS, v, v4);
        checks++;
        if (v !== 32'h2) begin
            errors++;
            $display("FAIL reserved_status: got %h required %h", v, 32'h2);
        end
        rd_reg(R_CTRL, v, v4);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reserved_ctrl: got %h required %h", v, 32'h0);
        end
        wr(BASE + 32'h1C, 32'hAAAA_5555);
        wr(BASE - 32'h4, 32'h5555_AAAA);
        wr(BASE + R_STATUS, 32'h0);
        wr(BASE + R_RESULT, 32'h0);
        rd_reg(R_OPERAND, v, v4);
        checks++;
        if (v !== 32'h1234_5678) begin
            errors++;
            $display("FAIL unmapped_operand: got %h required %h", v, 32'h1234_5678);
        end
        rd_reg(R_RESULT, v, v4);
        checks++;
        if (v !== 32'h6780_0000) begin
            errors++;
            $display("FAIL ro_result_write: got %h required %h", v, 32'h6780_0000);
        end
        rd_reg(R_STATUS, v, v4);
        checks++;
        if (v !== 32'h2) begin
            errors++;
            $display("FAIL ro_status_write: got %h required %h", v, 32'h2);
        end
        rd_reg(32'h1C, v, v4);
        checks++;
        if (v !== 32'h0 || hit !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_1c: rd=%h hit=%b required rd=0 hit=0", v, hit);
        end
        rd_reg(32'h14, v, v4);
        checks++;
        if (v !== 32'h0 || hit !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_14: rd=%h hit=%b required rd=0 hit=0", v, hit);
        end
        addr = BASE - 32'h4;
        #1;
        checks++;
        if (rd !== 32'h0 || hit !== 1'b0) begin
            errors++;
            $display("FAIL below_base: rd=%h hit=%b required rd=0 hit=0", rd, hit);
        end
        rd_reg(R_RESULT, v, v4);
        checks++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL hit_mapped: got %b required 1", hit);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] v, v4;
        wr(BASE + R_SHAMT, 32'd31);
        wr(BASE + R_CTRL, 32'h1);
        repeat (3) @(negedge clk);
        addr = BASE + R_STATUS;
        rst_n = 1'b0;
        #0.001;
        checks++;
        if (rd !== 32'h0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_status: rd=%h done_o=%b required 0/0", rd, done_o);
        end
        addr = BASE + R_RESULT;
        #0.001;
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL midreset_result: got %h required %h", rd, 32'h0);
        end
        rst_n = 1'b1;
        wr(BASE + R_OPERAND, 32'hF000_0000);
        wr(BASE + R_SHAMT, 32'h4);
        wr(BASE + R_CTRL, 32'h3);
        wait_done();
        rd_reg(R_RESULT, v, v4);
        checks++;
        if (v !== 32'h0F00_0000) begin
            errors++;
            $display("FAIL post_reset_result: got %h required %h", v, 32'h0F00_0000);
        end
    endtask

    initial begin
        addr  = 32'h0;
        we    = 1'b0;
        wd    = 32'h0;
        rst_n = 1'b0;
        test_reset();
        test_sra();
        test_sra_neg();
        test_sll_max();
        test_zero_and_busy();
        test_reserved_unmapped();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
